// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC access sequencer.
//   - V3023 time register addresses, swept in the order sec..year
//   - NUM_REGS: number of registers in one snapshot sweep
//   - rtc_state_e: sequencer FSM encoding, also exported on the debug port
//   - reg_addr(): maps a sweep index (0..5) to its bus address
package rtc_pkg;

  localparam int NUM_REGS = 6;

  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DAY   = 8'h24;
  localparam logic [7:0] ADDR_MONTH = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;

  localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_FIN = 2'd2,
    ST_COMMIT   = 2'd3
  } rtc_state_e;

  // The time registers are contiguous, so the sweep index is an offset from sec.
  function automatic logic [7:0] reg_addr(input logic [2:0] idx);
    return ADDR_SEC + {5'b0, idx};
  endfunction

endpackage

// File: rtl/rtc_poll_timer.sv
// Sweep-interval timer.
// Counts 0..POLL_DIV-1 while enable_i is high and emits a one-cycle tick on the
// last count. The count holds while enable_i is low.
// Ports:
//   Clock_in  - system clock
//   Reset     - synchronous, active-high
//   enable_i  - count enable
//   tick_o    - one-cycle expiry pulse
module rtc_poll_timer #(
  parameter int POLL_DIV = 10_000_000
) (
  input  logic Clock_in,
  input  logic Reset,
  input  logic enable_i,
  output logic tick_o
);

  localparam int CW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(POLL_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    tick_o  = 1'b0;
    if (enable_i) begin
      if (count_q == LAST) begin
        count_d = '0;
        tick_o  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock_in) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/rtc_access_sequencer.sv
// Schedules all traffic to the V3023 bus transaction engine.
// Periodically sweeps the six time registers into a staging area and, once the
// whole sweep has completed, copies it to the snapshot outputs in one step.
// Single-register writes from the set-time logic take priority at transaction
// boundaries; a completed write restarts the sweep so the snapshot picks up
// the new value.
//
// Handshake with the engine: xfer_start_o is a one-cycle pulse; xfer_write_o,
// xfer_addr_o and xfer_wdata_o are registered, valid on the start cycle and
// held until a new transaction is issued. The engine strobes read data with
// xfer_data_valid_i (last strobe wins) and ends with a one-cycle xfer_fin_i.
// wr_req_i is a one-cycle request accepted whenever no write is outstanding;
// wr_busy_o stays high until the write completes or times out.
//
// Ports:
//   Clock_in, Reset         - clock, synchronous active-high reset
//   enable_i                - gates new transactions (in-flight one completes)
//   wr_req_i/addr/data      - write request from the set-time logic
//   wr_busy_o, wr_ack_o     - write outstanding / one-cycle completion pulse
//   xfer_*                  - transaction engine interface
//   sec_o..year_o           - coherent time snapshot
//   snap_valid_o            - one-cycle pulse in the cycle the snapshot loads;
//                             new values are visible from the following cycle
//   err_o                   - sticky transaction-timeout flag
//   dbg_state_o             - current FSM state
module rtc_access_sequencer
  import rtc_pkg::*;
#(
  parameter int POLL_DIV = 10_000_000,
  parameter int TIMEOUT  = 4096
) (
  input  logic       Clock_in,
  input  logic       Reset,
  input  logic       enable_i,
  input  logic       wr_req_i,
  input  logic [7:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  output logic       wr_busy_o,
  output logic       wr_ack_o,
  output logic       xfer_start_o,
  output logic       xfer_write_o,
  output logic [7:0] xfer_addr_o,
  output logic [7:0] xfer_wdata_o,
  input  logic       xfer_data_valid_i,
  input  logic [7:0] xfer_rdata_i,
  input  logic       xfer_fin_i,
  output logic [7:0] sec_o,
  output logic [7:0] min_o,
  output logic [7:0] hour_o,
  output logic [7:0] day_o,
  output logic [7:0] month_o,
  output logic [7:0] year_o,
  output logic       snap_valid_o,
  output logic       err_o,
  output rtc_state_e dbg_state_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  rtc_state_e    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          poll_pending_q, poll_pending_d;
  logic          wr_busy_q, wr_busy_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          xfer_write_q, xfer_write_d;
  logic [7:0]    xfer_addr_q, xfer_addr_d;
  logic [7:0]    xfer_wdata_q, xfer_wdata_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [7:0]    staging_q [NUM_REGS];
  logic [7:0]    staging_d [NUM_REGS];
  logic [7:0]    snap_q [NUM_REGS];
  logic [7:0]    snap_d [NUM_REGS];

  logic poll_tick;
  logic wr_clear;

  rtc_poll_timer #(.POLL_DIV(POLL_DIV)) u_poll_timer (
    .Clock_in (Clock_in),
    .Reset    (Reset),
    .enable_i (enable_i),
    .tick_o   (poll_tick)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    poll_pending_d = poll_pending_q;
    wr_busy_d      = wr_busy_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    xfer_write_d   = xfer_write_q;
    xfer_addr_d    = xfer_addr_q;
    xfer_wdata_d   = xfer_wdata_q;
    tmo_d          = tmo_q;
    err_d          = err_q;
    staging_d      = staging_q;
    snap_d         = snap_q;
    xfer_start_o   = 1'b0;
    wr_ack_o       = 1'b0;
    snap_valid_o   = 1'b0;
    wr_clear       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The timeout count starts at 0 on the xfer_start cycle.
        tmo_d = '0;
        if (enable_i) begin
          if (wr_busy_q) begin
            state_d      = ST_ISSUE;
            xfer_write_d = 1'b1;
            xfer_addr_d  = wr_addr_q;
            xfer_wdata_d = wr_data_q;
          end else if (idx_q != 3'd0) begin
            state_d      = ST_ISSUE;
            xfer_write_d = 1'b0;
            xfer_addr_d  = reg_addr(idx_q);
            xfer_wdata_d = 8'h00;
          end else if (poll_pending_q) begin
            state_d        = ST_ISSUE;
            idx_d          = 3'd0;
            poll_pending_d = 1'b0;
            xfer_write_d   = 1'b0;
            xfer_addr_d    = ADDR_SEC;
            xfer_wdata_d   = 8'h00;
          end
        end
      end

      ST_ISSUE: begin
        xfer_start_o = 1'b1;
        tmo_d        = tmo_q + 1'b1;
        state_d      = ST_WAIT_FIN;
      end

      ST_WAIT_FIN: begin
        tmo_d = tmo_q + 1'b1;
        // Only read data belongs in staging; a write's data phase is ignored.
        if (xfer_data_valid_i && !xfer_write_q) staging_d[idx_q] = xfer_rdata_i;
        // fin arriving on the timeout cycle still completes normally.
        if (xfer_fin_i) begin
          state_d = ST_COMMIT;
        end else if (tmo_q == TMO_LAST) begin
          err_d     = 1'b1;
          idx_d     = 3'd0;
          staging_d = '{default: 8'h00};
          wr_clear  = xfer_write_q;
          state_d   = ST_IDLE;
        end
      end

      ST_COMMIT: begin
        if (xfer_write_q) begin
          wr_ack_o       = 1'b1;
          wr_clear       = 1'b1;
          idx_d          = 3'd0;
          poll_pending_d = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          snap_valid_o = 1'b1;
          snap_d       = staging_q;
          idx_d        = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A request arriving in the cycle the outstanding write retires is taken.
    if (wr_clear) wr_busy_d = 1'b0;
    if (wr_req_i && (!wr_busy_q || wr_clear)) begin
      wr_busy_d = 1'b1;
      wr_addr_d = wr_addr_i;
      wr_data_d = wr_data_i;
    end

    // Expiry mid-sweep only leaves a request for the next sweep.
    if (poll_tick) poll_pending_d = 1'b1;
  end

  always_ff @(posedge Clock_in) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= 3'd0;
      poll_pending_q <= 1'b1;
      wr_busy_q      <= 1'b0;
      wr_addr_q      <= 8'h00;
      wr_data_q      <= 8'h00;
      xfer_write_q   <= 1'b0;
      xfer_addr_q    <= 8'h00;
      xfer_wdata_q   <= 8'h00;
      tmo_q          <= '0;
      err_q          <= 1'b0;
      staging_q      <= '{default: 8'h00};
      snap_q         <= '{default: 8'h00};
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      poll_pending_q <= poll_pending_d;
      wr_busy_q      <= wr_busy_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      xfer_write_q   <= xfer_write_d;
      xfer_addr_q    <= xfer_addr_d;
      xfer_wdata_q   <= xfer_wdata_d;
      tmo_q          <= tmo_d;
      err_q          <= err_d;
      staging_q      <= staging_d;
      snap_q         <= snap_d;
    end
  end

  assign wr_busy_o    = wr_busy_q;
  assign xfer_write_o = xfer_write_q;
  assign xfer_addr_o  = xfer_addr_q;
  assign xfer_wdata_o = xfer_wdata_q;
  assign err_o        = err_q;
  assign dbg_state_o  = state_q;
  assign sec_o        = snap_q[0];
  assign min_o        = snap_q[1];
  assign hour_o       = snap_q[2];
  assign day_o        = snap_q[3];
  assign month_o      = snap_q[4];
  assign year_o       = snap_q[5];

endmodule

// File: tb/tb_rtc_access_sequencer.sv
module tb_rtc_access_sequencer;
  import rtc_pkg::*;

  localparam int POLL_DIV = 200;
  localparam int TIMEOUT  = 300;

  // ---------------- clock / reset ----------------
  logic Clock_in = 1'b0;
  logic Reset;
  always #5 Clock_in = ~Clock_in;

  logic       enable, wr_req;
  logic [7:0] wr_addr, wr_data;
  logic       wr_busy, wr_ack, xfer_start, xfer_write;
  logic [7:0] xfer_addr, xfer_wdata;
  logic       xfer_data_valid, xfer_fin;
  logic [7:0] xfer_rdata;
  logic [7:0] s_sec, s_min, s_hour, s_day, s_month, s_year;
  logic       snap_valid, err;
  rtc_state_e dbg_state;
  logic [47:0] snap_w;
  assign snap_w = {s_sec, s_min, s_hour, s_day, s_month, s_year};

  rtc_access_sequencer #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT)) dut (
    .Clock_in          (Clock_in),
    .Reset             (Reset),
    .enable_i          (enable),
    .wr_req_i          (wr_req),
    .wr_addr_i         (wr_addr),
    .wr_data_i         (wr_data),
    .wr_busy_o         (wr_busy),
    .wr_ack_o          (wr_ack),
    .xfer_start_o      (xfer_start),
    .xfer_write_o      (xfer_write),
    .xfer_addr_o       (xfer_addr),
    .xfer_wdata_o      (xfer_wdata),
    .xfer_data_valid_i (xfer_data_valid),
    .xfer_rdata_i      (xfer_rdata),
    .xfer_fin_i        (xfer_fin),
    .sec_o             (s_sec),
    .min_o             (s_min),
    .hour_o            (s_hour),
    .day_o             (s_day),
    .month_o           (s_month),
    .year_o            (s_year),
    .snap_valid_o      (snap_valid),
    .err_o             (err),
    .dbg_state_o       (dbg_state)
  );

  int n_pass = 0;
  int n_total = 0;

  // ---------------- engine model ----------------
  // fin 40 cycles after start, data_valid on cycles 30..35, rdata = addr + rd_ofs.
  // Every observed transaction is logged as {write, addr, wdata}.
  logic [16:0] obs_q[$];
  logic        fin_en = 1'b1;
  logic [7:0]  rd_ofs = 8'h10;
  logic        eng_active;
  int          eng_k;
  logic [7:0]  eng_addr;

  initial begin
    xfer_data_valid = 1'b0;
    xfer_fin        = 1'b0;
    xfer_rdata      = 8'h00;
    eng_active      = 1'b0;
    eng_k           = 0;
    eng_addr        = 8'h00;
    forever begin
      @(negedge Clock_in);
      if (Reset) begin
        eng_active      = 1'b0;
        xfer_data_valid = 1'b0;
        xfer_fin        = 1'b0;
        xfer_rdata      = 8'h00;
      end else begin
        if (xfer_start) begin
          eng_active = 1'b1;
          eng_k      = 0;
          eng_addr   = xfer_addr;
          obs_q.push_back({xfer_write, xfer_addr, xfer_wdata});
        end else if (eng_active) begin
          eng_k++;
        end
        if (eng_active) begin
          xfer_data_valid = (eng_k + 1 >= 30) && (eng_k + 1 <= 35);
          xfer_fin        = fin_en && (eng_k + 1 == 40);
          xfer_rdata      = xfer_data_valid ? eng_addr + rd_ofs : 8'h00;
          if (eng_k + 1 >= 40) eng_active = 1'b0;
        end else begin
          xfer_data_valid = 1'b0;
          xfer_fin        = 1'b0;
          xfer_rdata      = 8'h00;
        end
      end
    end
  end

  // ---------------- event counters ----------------
  int start_cnt = 0, snap_cnt = 0, ack_cnt = 0;
  always @(negedge Clock_in) begin
    if (xfer_start) start_cnt++;
    if (snap_valid) snap_cnt++;
    if (wr_ack)     ack_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge Clock_in);
    #1;
  endtask

  // which: 0 = xfer_start (optionally at addr), 1 = snap_valid, 2 = wr_ack
  task automatic wait_for(input int which, input logic [7:0] addr, input bit any_addr,
                          input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      step();
      case (which)
        0:       found = xfer_start && (any_addr || xfer_addr == addr);
        1:       found = snap_valid;
        default: found = wr_ack;
      endcase
    end
  endtask

  task automatic pulse_wr(input logic [7:0] a, input logic [7:0] d);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_req  = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b1; enable = 1'b1; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    repeat (3) step();
    n_total++;
    if ({xfer_start, xfer_write, xfer_addr, xfer_wdata, wr_busy, wr_ack, snap_valid, err} !== 28'h0)
      $display("FAIL reset_ctrl: got %h want 0",
               {xfer_start, xfer_write, xfer_addr, xfer_wdata, wr_busy, wr_ack, snap_valid, err});
    else n_pass++;
    n_total++;
    if (snap_w !== 48'h0) $display("FAIL reset_snap: got %h want 0", snap_w);
    else n_pass++;
    n_total++;
    if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    else n_pass++;
    obs_q.delete();
    Reset = 1'b0;
  endtask

  task automatic test_first_sweep();
    bit found;
    logic [16:0] e;
    wait_for(1, 8'h00, 1'b1, 400, found);
    n_total++;
    if (!found) $display("FAIL sweep_snap_wait: snap_valid not seen within 400 cycles");
    else n_pass++;
    n_total++;
    if (obs_q.size() != 6) $display("FAIL sweep_count: got %0d transactions want 6", obs_q.size());
    else n_pass++;
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      e = {1'b0, 8'(8'h21 + i), 8'h00};
      n_total++;
      if (obs_q[i] !== e) $display("FAIL sweep_xfer%0d: got %h want %h", i, obs_q[i], e);
      else n_pass++;
    end
    n_total++;
    if (snap_w !== 48'h0) $display("FAIL sweep_no_early_update: got %h want 0", snap_w);
    else n_pass++;
    n_total++;
    if (snap_cnt != 1) $display("FAIL sweep_snap_count: got %0d want 1", snap_cnt);
    else n_pass++;
    step();
    n_total++;
    if (snap_w !== 48'h313233343536) $display("FAIL sweep_snapshot: got %h want 313233343536", snap_w);
    else n_pass++;
    n_total++;
    if (err !== 1'b0) $display("FAIL sweep_err: got %b want 0", err);
    else n_pass++;
  endtask

  int ack_base;

  task automatic test_write_during_read();
    bit found;
    wait_for(0, 8'h23, 1'b0, 400, found);
    n_total++;
    if (!found) $display("FAIL wr_wait_read23: read of 0x23 not seen");
    else n_pass++;
    obs_q.delete();
    ack_base = ack_cnt;
    pulse_wr(8'h22, 8'h59);
    n_total++;
    if (wr_busy !== 1'b1) $display("FAIL wr_busy_set: got %b want 1", wr_busy);
    else n_pass++;
  endtask

  task automatic test_dropped_write();
    bit found;
    logic [16:0] e;
    repeat (3) step();
    pulse_wr(8'h24, 8'h77);
    n_total++;
    if (wr_busy !== 1'b1) $display("FAIL drop_busy: got %b want 1", wr_busy);
    else n_pass++;
    wait_for(2, 8'h00, 1'b1, 200, found);
    n_total++;
    if (!found) $display("FAIL drop_ack_wait: wr_ack not seen");
    else n_pass++;
    n_total++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 8'h22, 8'h59})
      $display("FAIL wr_xfer: got %0d entries first %h want 1 entry 12259",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 17'h0);
    else n_pass++;
    step();
    n_total++;
    if (wr_busy !== 1'b0) $display("FAIL wr_busy_clear: got %b want 0", wr_busy);
    else n_pass++;
    wait_for(1, 8'h00, 1'b1, 400, found);
    n_total++;
    if (obs_q.size() != 7) $display("FAIL wr_resweep_count: got %0d want 7", obs_q.size());
    else n_pass++;
    for (int i = 1; i < 7 && i < obs_q.size(); i++) begin
      e = {1'b0, 8'(8'h20 + i), 8'h00};
      n_total++;
      if (obs_q[i] !== e) $display("FAIL wr_resweep%0d: got %h want %h", i, obs_q[i], e);
      else n_pass++;
    end
    n_total++;
    if (ack_cnt - ack_base != 1) $display("FAIL drop_ack_count: got %0d want 1", ack_cnt - ack_base);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit found;
    wait_for(0, 8'h00, 1'b1, 100, found);
    obs_q.delete();
    pulse_wr(8'h26, 8'h01);
    wait_for(2, 8'h00, 1'b1, 200, found);
    n_total++;
    if (!found) $display("FAIL b2b_ack1: wr_ack not seen");
    else n_pass++;
    // New request in the ack cycle must be accepted.
    pulse_wr(8'h25, 8'h12);
    n_total++;
    if (wr_busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", wr_busy);
    else n_pass++;
    wait_for(2, 8'h00, 1'b1, 200, found);
    n_total++;
    if (obs_q.size() != 2 || obs_q[1] !== {1'b1, 8'h25, 8'h12})
      $display("FAIL b2b_xfer: got %0d entries last %h want 2 entries last 12512",
               obs_q.size(), obs_q.size() > 1 ? obs_q[1] : 17'h0);
    else n_pass++;
  endtask

  task automatic test_enable_pause();
    bit found;
    int s0;
    wait_for(0, 8'h23, 1'b0, 400, found);
    n_total++;
    if (!found) $display("FAIL en_wait_read23: read of 0x23 not seen");
    else n_pass++;
    enable = 1'b0;
    s0 = start_cnt;
    repeat (150) step();
    n_total++;
    if (start_cnt != s0) $display("FAIL en_no_start: got %0d starts want 0", start_cnt - s0);
    else n_pass++;
    n_total++;
    if (dbg_state !== ST_IDLE) $display("FAIL en_idle: got %0d want %0d", dbg_state, ST_IDLE);
    else n_pass++;
    enable = 1'b1;
    wait_for(0, 8'h00, 1'b1, 10, found);
    n_total++;
    if (!found || xfer_addr !== 8'h24) $display("FAIL en_resume: found %b addr %h want 24", found, xfer_addr);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bit found;
    wait_for(0, 8'h00, 1'b1, 100, found);
    fin_en = 1'b0;
    repeat (299) step();
    n_total++;
    if (err !== 1'b0) $display("FAIL tmo_early: err got %b want 0 at start+299", err);
    else n_pass++;
    step();
    n_total++;
    if (err !== 1'b1) $display("FAIL tmo_err: err got %b want 1 at start+300", err);
    else n_pass++;
    fin_en = 1'b1;
    rd_ofs = 8'h40;
    wait_for(0, 8'h00, 1'b1, 10, found);
    n_total++;
    if (!found || xfer_addr !== 8'h21) $display("FAIL tmo_restart: found %b addr %h want 21", found, xfer_addr);
    else n_pass++;
    wait_for(1, 8'h00, 1'b1, 400, found);
    n_total++;
    if (!found || snap_w !== 48'h313233343536)
      $display("FAIL tmo_snap_hold: found %b snap %h want 313233343536", found, snap_w);
    else n_pass++;
    step();
    n_total++;
    if (snap_w !== 48'h616263646566) $display("FAIL tmo_snap_new: got %h want 616263646566", snap_w);
    else n_pass++;
    n_total++;
    if (err !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found;
    wait_for(0, 8'h00, 1'b1, 100, found);
    repeat (10) step();
    Reset = 1'b1;
    step();
    n_total++;
    if ({xfer_start, xfer_write, xfer_addr, xfer_wdata, wr_busy, wr_ack, snap_valid, err} !== 28'h0)
      $display("FAIL rst_mid_ctrl: got %h want 0",
               {xfer_start, xfer_write, xfer_addr, xfer_wdata, wr_busy, wr_ack, snap_valid, err});
    else n_pass++;
    n_total++;
    if (snap_w !== 48'h0) $display("FAIL rst_mid_snap: got %h want 0", snap_w);
    else n_pass++;
    n_total++;
    if (dbg_state !== ST_IDLE) $display("FAIL rst_mid_state: got %0d want %0d", dbg_state, ST_IDLE);
    else n_pass++;
    Reset = 1'b0;
    wait_for(0, 8'h00, 1'b1, 10, found);
    n_total++;
    if (!found || xfer_addr !== 8'h21) $display("FAIL rst_mid_restart: found %b addr %h want 21", found, xfer_addr);
    else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_first_sweep();
    test_write_during_read();
    test_dropped_write();
    test_back_to_back();
    test_enable_pause();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtc_access_sequencer.md
# rtc_access_sequencer

Schedules all traffic to the V3023 RTC bus transaction engine, which performs one address-then-data cycle per start pulse and signals completion with a one-cycle Fin. The sequencer periodically sweeps the six time registers into a coherent shadow snapshot for the display path. It also arbitrates single-register write requests from the set-time logic. Writes have priority at transaction boundaries.

## Interface

Parameters:
- POLL_DIV, 10_000_000: Clock_in cycles between sweep starts (100 ms at 100 MHz).
- TIMEOUT, 4096: maximum cycles from xfer_start to xfer_fin before the transaction is abandoned.

Ports:
- Clock_in  in  1  system clock, 100 MHz
- Reset  in  1  synchronous, active-high
- enable  in  1  when low, no new transaction is started; an in-flight one completes
- wr_req  in  1  one-cycle write request pulse
- wr_addr  in  8  RTC register address for the write
- wr_data  in  8  data for the write
- wr_busy  out  1  write captured, not yet completed
- wr_ack  out  1  one-cycle pulse on write completion
- xfer_start  out  1  one-cycle start pulse to the engine
- xfer_write  out  1  1 = write transaction, 0 = read transaction
- xfer_addr  out  8  register address, held during the transaction
- xfer_wdata  out  8  write data, held during the transaction
- xfer_data_valid  in  1  engine data-phase strobe (multi-cycle)
- xfer_rdata  in  8  read data from the bus
- xfer_fin  in  1  engine completion pulse
- sec, min, hour, day, month, year  out  8 each  shadow snapshot
- snap_valid  out  1  one-cycle pulse when the snapshot updates
- err  out  1  sticky timeout flag, cleared only by Reset

## Operation

- Sweep order is fixed: index 0..5 = sec, min, hour, day, month, year. Addresses are 0x21..0x26.
- Poll counter:
  - counts 0..POLL_DIV-1 while enable is high, then sets poll_pending.
  - poll_pending clears when a sweep starts at index 0.
  - poll_pending resets to 1, so the first sweep starts immediately after reset.
- Write capture:
  - wr_req while wr_busy=0 latches wr_addr and wr_data and sets wr_busy.
  - wr_req while wr_busy=1 is dropped.
- FSM states: IDLE, ISSUE, WAIT_FIN, COMMIT.
- IDLE, enable=1, checked in this priority order:
  1. wr_busy: go to ISSUE as a write.
  2. A sweep in progress (idx>0): go to ISSUE as a read of idx.
  3. poll_pending: set idx=0, go to ISSUE as a read.
- ISSUE: xfer_start=1 for exactly one cycle, then go to WAIT_FIN.
- WAIT_FIN:
  - On each cycle with xfer_data_valid=1, load xfer_rdata into staging[idx]; the last value wins.
  - On xfer_fin, go to COMMIT.
  - If the timeout counter reaches TIMEOUT-1 first: set err, abandon the sweep (idx=0, staging discarded), go to IDLE.
  - A timed-out write still clears wr_busy but gives no wr_ack.
- COMMIT, after a write: pulse wr_ack, clear wr_busy, set idx=0 and poll_pending=1. The sweep restarts so the snapshot reflects the new value.
- COMMIT, after a read:
  - idx<5: idx++.
  - idx==5: copy all six staging registers to the outputs simultaneously, pulse snap_valid, set idx=0.
  - Return to IDLE in both cases.
- Snapshot outputs change only in COMMIT of index 5 and are never partially updated.

## Timing

- Reset values:
  - all outputs 0, state IDLE, idx 0, staging 0, poll counter 0, poll_pending 1.
  - wr_busy and err are 0.
- Decision latency: IDLE to xfer_start is 1 cycle.
- xfer_addr, xfer_write and xfer_wdata are registered. They are valid on the xfer_start cycle and stable until the cycle after xfer_fin.
- xfer_fin to wr_ack or snap_valid: 1 cycle (COMMIT).
- xfer_fin arriving on the same cycle as a timeout: fin wins, no err.
- xfer_fin outside WAIT_FIN is ignored.
- wr_req on the same cycle as the wr_ack pulse is accepted (wr_busy was already cleared in that cycle's COMMIT → re-set).
- Poll expiry during a sweep only sets poll_pending. The flag is consumed after the current sweep.
- Reset mid-transaction: immediate return to reset values; the engine is reset by the same Reset.

## Structure

- rtc_pkg: register address constants (ADDR_SEC..ADDR_YEAR), NUM_REGS=6, FSM state encoding.
- One sub-module, rtc_poll_timer: POLL_DIV counter with enable, outputs a one-cycle expiry tick.
- The sequencer instantiates the timer. The existing transaction engine sits outside this block, connected through the xfer_* ports.

## Test plan

All scenarios use POLL_DIV=200, TIMEOUT=300, and an engine model that asserts fin 40 cycles after start and data_valid on cycles 30-35 with rdata = addr+0x10.
- Release reset → six reads at 0x21..0x26 → snap_valid once, sec=0x31 … year=0x36, err=0.
- wr_req (0x22, 0x59) during the read of 0x23 → the read completes, then a write to 0x22 with data 0x59 → wr_ack → a full sweep restarts at 0x21.
- Second wr_req while wr_busy=1 → dropped, exactly one write is issued.
- Engine never asserts fin → err=1 at start+300 → next poll starts a sweep at 0x21, snapshot unchanged until it completes.
- enable=0 mid-sweep → the current read finishes, no further xfer_start; enable=1 → resumes at the next idx.
- Reset asserted during WAIT_FIN → all outputs 0 next cycle, and a new sweep begins after release.
